// File: rtl/gray_counter_n.sv
// gray_counter_n
//   Parametrised Gray-code counter with a binary view of the same count.
//   It counts up or down, supports a synchronous parallel load, and either
//   wraps or holds at the terminal value. It reports wrap or saturation
//   events with a sticky flag and a one-cycle pulse. Typical uses are
//   FIFO pointers and position encoders.
//
// Parameters
//   WIDTH    : counter width in bits, legal range 2..16
//   SATURATE : 0 = wrap at the terminal value, 1 = hold at the terminal value
//
// Ports
//   Clk      : clock; all state changes on the rising edge
//   Reset    : synchronous, active-high reset; overrides every other input
//   En       : count enable; one step per cycle while high
//   Dir      : 0 = count up, 1 = count down
//   Load     : parallel load strobe; has priority over En
//   LoadBin  : load value, binary-encoded
//   OvfClr   : clears Overflow; a simultaneous event wins
//   Gray     : registered count, Gray-encoded
//   Bin      : registered count, binary
//   Overflow : sticky flag; set by any wrap or saturation event
//   Wrap     : high for the cycle after each wrap or saturation event
module gray_counter_n #(
   parameter int WIDTH    = 3,
   parameter bit SATURATE = 1'b0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Dir,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadBin,
   input  logic             OvfClr,
   output logic [WIDTH-1:0] Gray,
   output logic [WIDTH-1:0] Bin,
   output logic             Overflow,
   output logic             Wrap
);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_ovf;
   logic             r_wrap;

   logic             w_at_top;
   logic             w_at_zero;
   logic             w_event;
   logic [WIDTH-1:0] w_bin_nxt;

   assign w_at_top  = (r_bin == {WIDTH{1'b1}});
   assign w_at_zero = (r_bin == '0);

   // The event is decided from the current count and the direction sampled
   // on this edge. A direction change therefore takes effect immediately.
   always_comb begin
      w_bin_nxt = r_bin;
      w_event   = 1'b0;
      if (Load) begin
         w_bin_nxt = LoadBin;
      end else if (En) begin
         if (!Dir) begin
            if (w_at_top) begin
               w_event = 1'b1;
               if (!SATURATE) w_bin_nxt = '0;
            end else begin
               w_bin_nxt = r_bin + WIDTH'(1);
            end
         end else begin
            if (w_at_zero) begin
               w_event = 1'b1;
               if (!SATURATE) w_bin_nxt = {WIDTH{1'b1}};
            end else begin
               w_bin_nxt = r_bin - WIDTH'(1);
            end
         end
      end
   end

   // The Gray register is loaded from the next binary value, not derived
   // from r_bin afterwards. Both outputs are therefore registered on the
   // same edge and always describe the same count.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_ovf  <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_bin_nxt ^ (w_bin_nxt >> 1);
         r_wrap <= w_event;
         if (w_event)     r_ovf <= 1'b1;
         else if (OvfClr) r_ovf <= 1'b0;
      end
   end

   assign Gray     = r_gray;
   assign Bin      = r_bin;
   assign Overflow = r_ovf;
   assign Wrap     = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Self-checking bench for gray_counter_n.
// Three instances share one stimulus stream:
//   u3 : WIDTH=3, wraps
//   u4 : WIDTH=4, saturates
//   u5 : WIDTH=5, wraps
// An integer model of each instance is compared on every falling edge.
// Directed sequences also pin the model with literal expected values.
module tb_gray_counter_n;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        En = 1'b0;
   logic        Dir = 1'b0;
   logic        Load = 1'b0;
   logic [15:0] LoadBin = '0;
   logic        OvfClr = 1'b0;

   logic [2:0] g3, b3;
   logic [3:0] g4, b4;
   logic [4:0] g5, b5;
   logic o3, w3, o4, w4, o5, w5;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u3 (
      .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
      .LoadBin(LoadBin[2:0]), .OvfClr(OvfClr),
      .Gray(g3), .Bin(b3), .Overflow(o3), .Wrap(w3));

   gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) u4 (
      .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
      .LoadBin(LoadBin[3:0]), .OvfClr(OvfClr),
      .Gray(g4), .Bin(b4), .Overflow(o4), .Wrap(w4));

   gray_counter_n #(.WIDTH(5), .SATURATE(1'b0)) u5 (
      .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
      .LoadBin(LoadBin[4:0]), .OvfClr(OvfClr),
      .Gray(g5), .Bin(b5), .Overflow(o5), .Wrap(w5));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the count is a plain integer.
   int  m_b[3];
   bit  m_o[3];
   bit  m_w[3];
   bit  m_stepped5;
   int  m_prevg5;
   bit  started = 1'b0;

   function automatic int to_gray(input int v);
      return v ^ (v >> 1);
   endfunction

   task automatic mstep(input int w, input bit sat, input int idx);
      int  top;
      int  nb;
      bit  ev;
      top = (1 << w) - 1;
      nb  = m_b[idx];
      ev  = 1'b0;
      if (Reset) begin
         m_b[idx] = 0;
         m_o[idx] = 1'b0;
         m_w[idx] = 1'b0;
         return;
      end
      if (Load) begin
         nb = int'(LoadBin) & top;
      end else if (En) begin
         if (!Dir) begin
            if (m_b[idx] == top) begin
               ev = 1'b1;
               if (!sat) nb = 0;
            end else begin
               nb = m_b[idx] + 1;
            end
         end else begin
            if (m_b[idx] == 0) begin
               ev = 1'b1;
               if (!sat) nb = top;
            end else begin
               nb = m_b[idx] - 1;
            end
         end
      end
      m_b[idx] = nb;
      m_w[idx] = ev;
      if (ev) m_o[idx] = 1'b1;
      else if (OvfClr) m_o[idx] = 1'b0;
   endtask

   always @(posedge Clk) begin
      bit step5;
      int old5;
      step5 = !Reset && !Load && En;
      old5  = m_b[2];
      mstep(3, 1'b0, 0);
      mstep(4, 1'b1, 1);
      mstep(5, 1'b0, 2);
      m_stepped5 = step5 && (m_b[2] != old5);
      m_prevg5   = to_gray(old5);
      if (Reset) started = 1'b1;
   end

   always @(negedge Clk) begin
      if (started) begin
         chk("u3.Bin",      int'(b3), m_b[0]);
         chk("u3.Gray",     int'(g3), to_gray(m_b[0]));
         chk("u3.Overflow", int'(o3), int'(m_o[0]));
         chk("u3.Wrap",     int'(w3), int'(m_w[0]));
         chk("u4.Bin",      int'(b4), m_b[1]);
         chk("u4.Gray",     int'(g4), to_gray(m_b[1]));
         chk("u4.Overflow", int'(o4), int'(m_o[1]));
         chk("u4.Wrap",     int'(w4), int'(m_w[1]));
         chk("u5.Bin",      int'(b5), m_b[2]);
         chk("u5.Gray",     int'(g5), to_gray(m_b[2]));
         chk("u5.Overflow", int'(o5), int'(m_o[2]));
         chk("u5.Wrap",     int'(w5), int'(m_w[2]));
         if (m_stepped5)
            chk("u5.gray_one_bit_step", $countones(int'(g5) ^ m_prevg5), 1);
      end
   end

   task automatic cyc(input bit en, input bit dir, input bit ld,
                      input int lb, input bit clr, input bit rst);
      En      = en;
      Dir     = dir;
      Load    = ld;
      LoadBin = 16'(lb);
      OvfClr  = clr;
      Reset   = rst;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      int up_g[9];
      up_g = '{1, 3, 2, 6, 7, 5, 4, 0, 1};

      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk("reset.Gray", int'(g3), 0);
      chk("reset.Bin", int'(b3), 0);
      chk("reset.Overflow", int'(o3), 0);
      chk("reset.Wrap", int'(w3), 0);

      // Up count through a wrap on the 3-bit instance.
      for (int i = 0; i < 9; i++) begin
         cyc(1, 0, 0, 0, 0, 0);
         chk("up3.Gray", int'(g3), up_g[i]);
         chk("up3.Bin", int'(b3), (i + 1) % 8);
         chk("up3.Wrap", int'(w3), (i == 7) ? 1 : 0);
         chk("up3.Overflow", int'(o3), (i >= 7) ? 1 : 0);
      end

      // Load 0, then count down through a wrap.
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("down3.Gray", int'(g3), 4);
      chk("down3.Bin", int'(b3), 7);
      chk("down3.Wrap", int'(w3), 1);
      cyc(1, 1, 0, 0, 0, 0);
      chk("down3.Gray2", int'(g3), 5);
      chk("down3.Bin2", int'(b3), 6);
      chk("down3.Wrap2", int'(w3), 0);
      chk("down3.Overflow", int'(o3), 1);

      // Saturation on the 4-bit instance.
      cyc(0, 0, 1, 14, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0);
         chk("sat4.Bin", int'(b4), 15);
         chk("sat4.Gray", int'(g4), 8);
         chk("sat4.Wrap", int'(w4), (i == 0) ? 0 : 1);
         chk("sat4.Overflow", int'(o4), 1);
      end

      // Load takes priority over En; a new event wins over OvfClr.
      cyc(1, 0, 1, 5, 0, 0);
      chk("ldpri.Bin", int'(b3), 5);
      chk("ldpri.Gray", int'(g3), 7);
      cyc(0, 0, 1, 7, 0, 0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("clrvsev.Bin", int'(b3), 0);
      chk("clrvsev.Overflow", int'(o3), 1);
      cyc(0, 0, 0, 0, 1, 0);
      chk("clr.Overflow", int'(o3), 0);

      // Reset in the middle of counting.
      cyc(0, 0, 1, 7, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 6, 0, 0);
      chk("midrst.pre.Overflow", int'(o3), 1);
      cyc(1, 0, 0, 0, 0, 1);
      chk("midrst.Bin", int'(b3), 0);
      chk("midrst.Gray", int'(g3), 0);
      chk("midrst.Overflow", int'(o3), 0);
      chk("midrst.Wrap", int'(w3), 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("midrst.resume.Gray", int'(g3), 1);

      // 64 steps each way: u5 wraps twice in each direction.
      for (int i = 0; i < 64; i++) cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) cyc(1, 1, 0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15) == 0, int'($urandom_range(0, 65535)),
             $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      end

      cyc(0, 0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised Gray-code counter that generalises the fixed 3-bit up-only Gray counter.
- Adds configurable width, up/down direction, synchronous parallel load, and a saturate-or-wrap mode.
- Adds a sticky overflow flag with clear, plus a one-cycle wrap pulse.
- Used as a sequence/pointer generator, e.g. FIFO pointers and position encoders; exposes both Gray and binary views of the count.

Parameters:
- WIDTH, 3, counter width in bits; legal 2..16.
- SATURATE, 0, 0 = wrap at the terminal value; 1 = hold at the terminal value.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  count enable; one step per cycle while high.
- Dir  input  1  0 = count up, 1 = count down; sampled with En.
- Load  input  1  synchronous parallel load strobe.
- LoadBin  input  WIDTH  load value, binary-encoded.
- OvfClr  input  1  clears the sticky Overflow flag.
- Gray  output  WIDTH  current count, Gray-encoded (registered).
- Bin  output  WIDTH  current count, binary (registered).
- Overflow  output  1  sticky flag: a wrap or saturation event has occurred.
- Wrap  output  1  one-cycle pulse, high the cycle after a wrap or saturation event.

Behaviour:
- State: WIDTH-bit binary count B.
- Output encoding: Gray = B ^ (B >> 1), registered together with B, so Gray and Bin always describe the same count.
- Up sequence for WIDTH=3: 000, 001, 011, 010, 110, 111, 101, 100, then back to 000. Exactly one Gray bit changes per step.
- Reset (Reset=1 at the edge): B=0, Gray=0, Bin=0, Overflow=0, Wrap=0. Reset overrides every other input, including mid-count and mid-load.
- Priority per edge: Reset > Load > En.
- Load=1: B <= LoadBin and Gray follows in the same edge. No counting that cycle, even if En=1. Wrap=0. Overflow is unchanged unless OvfClr applies.
- En=1, Load=0, Dir=0:
  - If B != all-ones, B <= B+1.
  - If B == all-ones and SATURATE=0: B <= 0 and a wrap event fires.
  - If B == all-ones and SATURATE=1: B holds and a saturation event fires.
- En=1, Load=0, Dir=1:
  - If B != 0, B <= B-1.
  - If B == 0 and SATURATE=0: B <= all-ones and a wrap event fires.
  - If B == 0 and SATURATE=1: B holds and a saturation event fires.
- En=0 and Load=0: B holds. Wrap=0.
- Wrap (registered): high for exactly the cycle after an event edge. Repeated saturation attempts give one pulse per attempted step, so Wrap stays high continuously while the count is held at the terminal with En=1.
- Overflow: set on any wrap or saturation event in either direction. Remains set until OvfClr=1 or Reset.
- OvfClr and a new event at the same edge: set wins, so Overflow stays 1.
- OvfClr with no event: Overflow <= 0 next edge.
- A direction change takes effect on the edge where it is sampled; no extra latency and no skipped codes.
- Arithmetic is modulo 2^WIDTH. No unknown values escape reset. All Gray/binary conversion logic is sized by WIDTH.

Test Plan:
- WIDTH=3, SATURATE=0: Reset, then En=1 Dir=0 for 9 cycles -> Gray = 001, 011, 010, 110, 111, 101, 100, 000, 001. Wrap high only the cycle Gray first reads 000. Overflow=1 from then on. Bin tracks 1..7, 0, 1.
- WIDTH=3: Load LoadBin=0 then En=1 Dir=1 for 2 cycles -> Gray 100 (Bin 111), then 101 (Bin 110). Overflow=1, Wrap pulse once.
- WIDTH=4, SATURATE=1: Load 1110, then En=1 Dir=0 for 3 cycles -> Bin 1111 (Gray 1000), held at 1111 for 2 more cycles. Wrap high 2 cycles. Overflow=1.
- Simultaneous events: Load=1 with En=1, LoadBin=5 (WIDTH=3) -> Bin=101, Gray=111, no step. Next cycle OvfClr=1 while the count wraps from 7 -> Overflow stays 1. OvfClr alone afterwards -> Overflow=0.
- Reset mid-operation: counting at Bin=6 with En=1 and Overflow=1, assert Reset for 1 cycle -> all outputs 0 next edge. Counting resumes at 001 after Reset drops.
- Exhaustive WIDTH=5 up/down run of 64 steps each -> each step changes exactly one Gray bit, and Gray == Bin ^ (Bin>>1) every cycle.
